// File: rtl/stub_readback_pkg.sv
// -----------------------------------------------------------------------------
// stub_readback_pkg
// Shared definitions for the stub readback capture block: register map
// addresses, CTRL register bit positions and the capture state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package stub_readback_pkg;

    // Register addresses, decoded from io_addr[1:0]
    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_DATA_LO = 2'd2;
    localparam logic [1:0] REG_DATA_HI = 2'd3;

    // CTRL register bit positions
    localparam int CTRL_ARM   = 0;
    localparam int CTRL_CLEAR = 1;
    localparam int CTRL_STOP  = 2;

    // Capture state machine encoding (visible in STATUS[29:28])
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/stub_readback_capture_if.sv
// -----------------------------------------------------------------------------
// stub_readback_capture_if
// IPbus-style programming interface of the readback capture block.
//   io_sel      module selected
//   io_sync     single-cycle start of an I/O operation
//   io_addr     register address (bits [1:0] decoded)
//   io_rd_en    read operation
//   io_wr_en    write operation
//   io_wr_data  write data
//   io_rd_data  read data (valid while io_rd_ack, held until the next read)
//   io_rd_ack   read data valid, one cycle after the request
// master: the bus side driving requests; slave: the capture block.
// -----------------------------------------------------------------------------
interface stub_readback_capture_if;

    logic        io_sel;
    logic        io_sync;
    logic [15:0] io_addr;
    logic        io_rd_en;
    logic        io_wr_en;
    logic [31:0] io_wr_data;
    logic [31:0] io_rd_data;
    logic        io_rd_ack;

    modport master (
        output io_sel, io_sync, io_addr, io_rd_en, io_wr_en, io_wr_data,
        input  io_rd_data, io_rd_ack
    );

    modport slave (
        input  io_sel, io_sync, io_addr, io_rd_en, io_wr_en, io_wr_data,
        output io_rd_data, io_rd_ack
    );

endinterface

// File: rtl/stub_readback_capture_sdp_ram.sv
// -----------------------------------------------------------------------------
// readback_sdp_ram
// Simple dual-port buffer, 2^DEPTH_LOG2 x DATA_W: one synchronous write port
// and one asynchronous read port, so the head word is available in the same
// cycle its address is known.
//   clk      write clock
//   wr_en    write strobe
//   wr_addr  write address
//   wr_data  write data
//   rd_addr  read address
//   rd_data  combinational read data
// -----------------------------------------------------------------------------
module readback_sdp_ram #(
    parameter int DEPTH_LOG2 = 6,
    parameter int DATA_W     = 64
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [DATA_W-1:0]     rd_data
);

    logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

    // NOTE: the array has no reset; contents are only ever read behind the
    // count, and a reset term would stop it mapping onto RAM primitives.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/stub_readback_capture.sv
// -----------------------------------------------------------------------------
// stub_readback_capture
// Captures 64-bit words leaving a processing stage into an on-chip buffer for
// one software-armed event window, and lets software drain it as 32-bit halves
// over the IPbus-style interface.
//   clk        system clock
//   reset      synchronous, active-low reset
//   en_proc    processing enable; words captured only while high
//   first_clk  event-boundary strobe; opens the window when armed
//   data_in    processing-stage output word
//   valid_in   data_in qualifier
//   io         programming interface (slave modport)
//   buf_full   buffer holds 2^DEPTH_LOG2 words
//   overflow   sticky: a word was dropped because the buffer was full
// -----------------------------------------------------------------------------
module stub_readback_capture
    import stub_readback_pkg::*;
#(
    parameter int DEPTH_LOG2 = 6,
    parameter int DATA_W     = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en_proc,
    input  logic                first_clk,
    input  logic [DATA_W-1:0]   data_in,
    input  logic                valid_in,
    stub_readback_capture_if.slave io,
    output logic                buf_full,
    output logic                overflow
);

    localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam int                  PAD_W      = 28 - (DEPTH_LOG2 + 1);

    state_t                state, state_next, ctrl_base;
    logic [DEPTH_LOG2-1:0] wr_ptr, wr_ptr_next;
    logic [DEPTH_LOG2-1:0] rd_ptr, rd_ptr_next;
    logic [DEPTH_LOG2:0]   count, count_next;
    logic                  overflow_next;
    logic [31:0]           rd_data_next;
    logic [31:0]           rd_mux;
    logic [DATA_W-1:0]     head_word;

    logic access, wr_ctrl, rd_req;
    logic clear, arm, stop;
    logic is_full, is_empty, word_ok, window_open;
    logic push, pop;

    // Only the low address bits and the three CTRL bits carry meaning.
    logic unused_ok;
    assign unused_ok = &{1'b0, io.io_addr[15:2], io.io_wr_data[31:3]};

    readback_sdp_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_W     (DATA_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data (data_in),
        .rd_addr (rd_ptr),
        .rd_data (head_word)
    );

    // Request decode and data-path qualifiers
    always_comb begin
        access      = io.io_sel & io.io_sync;
        wr_ctrl     = access & io.io_wr_en & (io.io_addr[1:0] == REG_CTRL);
        rd_req      = access & io.io_rd_en;
        clear       = wr_ctrl & io.io_wr_data[CTRL_CLEAR];
        arm         = wr_ctrl & io.io_wr_data[CTRL_ARM];
        stop        = wr_ctrl & io.io_wr_data[CTRL_STOP];
        is_full     = (count == FULL_COUNT);
        is_empty    = (count == '0);
        word_ok     = valid_in & en_proc;
        // The strobe cycle's own word already belongs to the window.
        window_open = (state == CAPTURE) | ((state == ARMED) & first_clk);
        push        = ~clear & window_open & word_ok & ~is_full;
        // Pops only outside the window, so push and pop never coincide.
        pop         = ~clear & rd_req & (io.io_addr[1:0] == REG_DATA_HI) &
                      ((state == IDLE) | (state == DONE)) & ~is_empty;
    end

    // Next-state and buffer bookkeeping
    always_comb begin
        // NOTE: every output gets a default first so no path through this
        // block leaves a variable unassigned, which would infer a latch.
        state_next    = state;
        wr_ptr_next   = wr_ptr;
        rd_ptr_next   = rd_ptr;
        count_next    = count;
        overflow_next = overflow;
        ctrl_base     = state;

        if (clear) begin
            state_next    = IDLE;
            wr_ptr_next   = '0;
            rd_ptr_next   = '0;
            count_next    = '0;
            overflow_next = 1'b0;
            ctrl_base     = IDLE;
        end else begin
            if (push) begin
                wr_ptr_next = wr_ptr + 1'b1;
                count_next  = count + 1'b1;
            end
            if (pop) begin
                rd_ptr_next = rd_ptr + 1'b1;
                count_next  = count - 1'b1;
            end
            // Words still streaming at a full buffer after the window closed
            // on the fill are the ones that were lost.
            if (word_ok & is_full & (window_open | (state == DONE))) begin
                overflow_next = 1'b1;
            end
            case (state)
                ARMED:   if (first_clk) state_next = CAPTURE;
                default: state_next = state;
            endcase
            if ((state_next == CAPTURE) && (count_next == FULL_COUNT)) begin
                state_next = DONE;
            end
        end

        // CTRL applies after CLEAR; STOP suppresses ARM in the same write.
        if (stop) begin
            if ((ctrl_base == ARMED) || (ctrl_base == CAPTURE)) begin
                state_next = DONE;
            end
        end else if (arm) begin
            if ((ctrl_base == IDLE) || (ctrl_base == DONE)) begin
                state_next = ARMED;
            end
        end
    end

    // Read mux; empty buffer reads as zero on both data halves
    always_comb begin
        rd_mux = '0;
        case (io.io_addr[1:0])
            REG_STATUS:  rd_mux = {overflow, buf_full, state, {PAD_W{1'b0}}, count};
            REG_DATA_LO: rd_mux = is_empty ? 32'h0 : head_word[31:0];
            REG_DATA_HI: rd_mux = is_empty ? 32'h0 : head_word[63:32];
            default:     rd_mux = '0;
        endcase
        rd_data_next = rd_req ? rd_mux : io.io_rd_data;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            overflow      <= 1'b0;
            buf_full      <= 1'b0;
            io.io_rd_data <= '0;
            io.io_rd_ack  <= 1'b0;
        end else begin
            state         <= state_next;
            wr_ptr        <= wr_ptr_next;
            rd_ptr        <= rd_ptr_next;
            count         <= count_next;
            overflow      <= overflow_next;
            buf_full      <= (count_next == FULL_COUNT);
            io.io_rd_data <= rd_data_next;
            io.io_rd_ack  <= rd_req;
        end
    end

endmodule

// File: tb/tb_stub_readback_capture.sv
// -----------------------------------------------------------------------------
// tb_stub_readback_capture
// Directed bench for stub_readback_capture: register reads against a table of
// hand-computed values plus sequences for fill/overflow, en_proc gating,
// in-window reads, CTRL bit combinations and reset.
// -----------------------------------------------------------------------------
module tb_stub_readback_capture;
    import stub_readback_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en_proc = 1'b1;
    logic        first_clk = 1'b0;
    logic [63:0] data_in = '0;
    logic        valid_in = 1'b0;
    logic        buf_full;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    stub_readback_capture_if bus ();

    stub_readback_capture dut (
        .clk       (clk),
        .reset     (reset),
        .en_proc   (en_proc),
        .first_clk (first_clk),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .io        (bus),
        .buf_full  (buf_full),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_wr;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic w, logic [1:0] a, logic [31:0] wd,
                                logic [31:0] e, string n);
        vec_t v;
        v.is_wr = w; v.addr = a; v.wdata = wd; v.exp = e; v.name = n;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic io_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.io_sel = 1'b1; bus.io_sync = 1'b1; bus.io_rd_en = 1'b1;
        bus.io_addr = {14'b0, a};
        @(posedge clk); #1;
        bus.io_sel = 1'b0; bus.io_sync = 1'b0; bus.io_rd_en = 1'b0;
        check("rd_ack", {31'b0, bus.io_rd_ack}, 32'd1);
        d = bus.io_rd_data;
    endtask

    task automatic io_write(input logic [1:0] a, input logic [31:0] wd);
        @(negedge clk);
        bus.io_sel = 1'b1; bus.io_sync = 1'b1; bus.io_wr_en = 1'b1;
        bus.io_addr = {14'b0, a}; bus.io_wr_data = wd;
        @(posedge clk); #1;
        bus.io_sel = 1'b0; bus.io_sync = 1'b0; bus.io_wr_en = 1'b0;
    endtask

    task automatic read_expect(input logic [1:0] a, input logic [31:0] e,
                               input string name);
        logic [31:0] d;
        io_read(a, d);
        check(name, d, e);
    endtask

    task automatic push(input logic [63:0] w, input logic first);
        @(negedge clk);
        data_in = w; valid_in = 1'b1; first_clk = first;
        @(posedge clk); #1;
        valid_in = 1'b0; first_clk = 1'b0;
    endtask

    // Reset lands together with a read request and a valid word.
    task automatic reset_with_pending(input string tag);
        @(negedge clk);
        reset = 1'b0;
        bus.io_sel = 1'b1; bus.io_sync = 1'b1; bus.io_rd_en = 1'b1;
        bus.io_addr = {14'b0, REG_STATUS};
        valid_in = 1'b1; first_clk = 1'b1;
        @(posedge clk); #1;
        bus.io_sel = 1'b0; bus.io_sync = 1'b0; bus.io_rd_en = 1'b0;
        valid_in = 1'b0; first_clk = 1'b0;
        check({tag, "_ack"},      {31'b0, bus.io_rd_ack}, 32'd0);
        check({tag, "_rd_data"},  bus.io_rd_data,         32'd0);
        check({tag, "_buf_full"}, {31'b0, buf_full},      32'd0);
        check({tag, "_overflow"}, {31'b0, overflow},      32'd0);
        @(negedge clk);
        reset = 1'b1;
        read_expect(REG_STATUS, 32'h0, {tag, "_status"});
    endtask

    function automatic logic [63:0] fill_word(int i);
        return {32'hC0DE_0000 | 32'(i), 32'h0000_1000 + 32'(i)};
    endfunction

    initial begin
        logic [31:0] d;
        logic [63:0] w0;
        bus.io_sel = 1'b0; bus.io_sync = 1'b0; bus.io_addr = '0;
        bus.io_rd_en = 1'b0; bus.io_wr_en = 1'b0; bus.io_wr_data = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack",      {31'b0, bus.io_rd_ack}, 32'd0);
        check("rst_rd_data",  bus.io_rd_data,         32'd0);
        check("rst_buf_full", {31'b0, buf_full},      32'd0);
        check("rst_overflow", {31'b0, overflow},      32'd0);
        @(negedge clk);
        reset = 1'b1;
        check("ack_before_req", {31'b0, bus.io_rd_ack}, 32'd0);
        read_expect(REG_STATUS, 32'h0, "status_after_reset");
        @(posedge clk); #1;
        check("ack_one_cycle", {31'b0, bus.io_rd_ack}, 32'd0);

        // Words before first_clk are ignored; three words from the strobe on
        io_write(REG_CTRL, 32'h1);
        for (int i = 0; i < 3; i++) push(64'hDEAD_BEEF_0000_0000 | 64'(i), 1'b0);
        w0 = 64'h1111_2222_3333_4444;
        push(w0, 1'b1);
        push(w0 + 64'd1, 1'b0);
        push(w0 + 64'd2, 1'b0);
        io_write(REG_CTRL, 32'h4);

        vq.push_back(mk(1'b0, REG_STATUS,  0, 32'h3000_0003, "status_done3"));
        vq.push_back(mk(1'b0, REG_CTRL,    0, 32'h0000_0000, "ctrl_reads0"));
        vq.push_back(mk(1'b0, REG_DATA_LO, 0, 32'h3333_4444, "w0_lo"));
        vq.push_back(mk(1'b0, REG_DATA_HI, 0, 32'h1111_2222, "w0_hi"));
        vq.push_back(mk(1'b0, REG_STATUS,  0, 32'h3000_0002, "status_done2"));
        vq.push_back(mk(1'b0, REG_DATA_LO, 0, 32'h3333_4445, "w1_lo"));
        vq.push_back(mk(1'b0, REG_DATA_HI, 0, 32'h1111_2222, "w1_hi"));
        vq.push_back(mk(1'b1, REG_DATA_HI, 32'hDEAD_BEEF, 0, "wr_data_hi"));
        vq.push_back(mk(1'b1, REG_STATUS,  32'hFFFF_FFFF, 0, "wr_status"));
        vq.push_back(mk(1'b0, REG_STATUS,  0, 32'h3000_0001, "status_done1"));
        vq.push_back(mk(1'b0, REG_DATA_LO, 0, 32'h3333_4446, "w2_lo"));
        vq.push_back(mk(1'b0, REG_DATA_HI, 0, 32'h1111_2222, "w2_hi"));
        vq.push_back(mk(1'b0, REG_STATUS,  0, 32'h3000_0000, "status_done0"));
        vq.push_back(mk(1'b0, REG_DATA_LO, 0, 32'h0000_0000, "empty_lo"));
        vq.push_back(mk(1'b0, REG_DATA_HI, 0, 32'h0000_0000, "empty_hi"));
        vq.push_back(mk(1'b0, REG_STATUS,  0, 32'h3000_0000, "status_empty_pop"));
        vq.push_back(mk(1'b1, REG_CTRL,    32'h2, 0, "clear"));
        vq.push_back(mk(1'b0, REG_STATUS,  0, 32'h0000_0000, "status_cleared"));

        foreach (vq[k]) begin
            if (vq[k].is_wr) io_write(vq[k].addr, vq[k].wdata);
            else             read_expect(vq[k].addr, vq[k].exp, vq[k].name);
        end

        // Fill past capacity: window closes at 64, later words overflow
        io_write(REG_CTRL, 32'h1);
        for (int i = 0; i < 70; i++) begin
            push(fill_word(i), i == 0);
            if (i == 62) check("full_at_63", {31'b0, buf_full}, 32'd0);
            if (i == 63) begin
                check("full_at_64",     {31'b0, buf_full}, 32'd1);
                check("no_ovf_at_64",   {31'b0, overflow}, 32'd0);
            end
            if (i == 64) check("ovf_at_65", {31'b0, overflow}, 32'd1);
        end
        read_expect(REG_STATUS, 32'hF000_0040, "status_full");
        for (int i = 0; i < 64; i++) begin
            logic [63:0] e;
            e = fill_word(i);
            read_expect(REG_DATA_LO, e[31:0],  "drain_lo");
            read_expect(REG_DATA_HI, e[63:32], "drain_hi");
        end
        read_expect(REG_STATUS, 32'hB000_0000, "status_drained");

        // CLEAR+ARM after overflow
        io_write(REG_CTRL, 32'h3);
        read_expect(REG_STATUS, 32'h1000_0000, "clear_arm_status");
        check("clear_arm_ovf", {31'b0, overflow}, 32'd0);

        // en_proc gating and in-window reads
        push(64'hAAAA_0001_BBBB_0001, 1'b1);
        en_proc = 1'b0;
        for (int i = 0; i < 3; i++) push(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        en_proc = 1'b1;
        read_expect(REG_STATUS,  32'h2000_0001, "gated_status");
        read_expect(REG_DATA_HI, 32'hAAAA_0001, "capture_hi_nopop");
        read_expect(REG_STATUS,  32'h2000_0001, "capture_count_kept");
        read_expect(REG_DATA_LO, 32'hBBBB_0001, "capture_lo");
        push(64'h0, 1'b0);
        io_write(REG_CTRL, 32'h5);
        read_expect(REG_STATUS, 32'h3000_0002, "stop_beats_arm");
        io_write(REG_CTRL, 32'h1);
        read_expect(REG_STATUS, 32'h1000_0002, "rearm_appends");
        push(64'h1234_5678_9ABC_DEF0, 1'b1);
        io_write(REG_CTRL, 32'h4);
        read_expect(REG_STATUS,  32'h3000_0003, "append_status");
        read_expect(REG_DATA_LO, 32'hBBBB_0001, "app0_lo");
        read_expect(REG_DATA_HI, 32'hAAAA_0001, "app0_hi");
        read_expect(REG_DATA_LO, 32'h0000_0000, "zero_word_lo");
        read_expect(REG_DATA_HI, 32'h0000_0000, "zero_word_hi");
        read_expect(REG_STATUS,  32'h3000_0001, "zero_word_counted");
        read_expect(REG_DATA_LO, 32'h9ABC_DEF0, "app2_lo");
        read_expect(REG_DATA_HI, 32'h1234_5678, "app2_hi");
        io_write(REG_CTRL, 32'h2);
        read_expect(REG_DATA_LO, 32'h0, "idle_empty_lo");

        // Reset with a full, overflowed buffer and a held read value
        io_write(REG_CTRL, 32'h3);
        for (int i = 0; i < 66; i++) push(fill_word(i), i == 0);
        read_expect(REG_STATUS, 32'hF000_0040, "status_before_reset");
        @(posedge clk); #1;
        check("ack_dropped",  {31'b0, bus.io_rd_ack}, 32'd0);
        check("rd_data_held", bus.io_rd_data,         32'hF000_0040);
        reset_with_pending("rst_full");

        // Reset mid-capture
        io_write(REG_CTRL, 32'h1);
        for (int i = 0; i < 5; i++) push(fill_word(i), i == 0);
        read_expect(REG_STATUS, 32'h2000_0005, "status_mid_capture");
        reset_with_pending("rst_capture");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stub_readback_capture.md
Name: stub_readback_capture

Overview:
- Receive-side counterpart of the IPbus stub injector: captures 64-bit words leaving a processing stage (data/valid pairs) into an on-chip buffer.
- The buffer is read back over the IPbus-style programming interface as 32-bit halves.
- Sits at the output end of a tracklet processing chain. Software arms a capture, the block records one event window, and software drains it.
- Single clock domain: all io_* signals are synchronous to clk.

Parameters:
- DEPTH_LOG2, 6, log2 of buffer depth in 64-bit entries (64 entries).
- DATA_W, 64, captured word width; fixed at 64 for the 2x32 readout.

Ports:
- clk  in  1  system clock; all io_* signals are synchronous to it.
- reset  in  1  synchronous, active-low reset.
- en_proc  in  1  processing enable; words are captured only while high.
- first_clk  in  1  event-boundary strobe; starts capture when armed.
- data_in  in  64  processing-stage output word.
- valid_in  in  1  data_in qualifier.
- io_sel  in  1  module selected.
- io_sync  in  1  single-cycle start of an I/O operation.
- io_addr  in  16  register address; bits [1:0] decoded.
- io_rd_en  in  1  read operation.
- io_wr_en  in  1  write operation.
- io_wr_data  in  32  write data.
- io_rd_data  out  32  read data.
- io_rd_ack  out  1  read data valid.
- buf_full  out  1  buffer holds 2^DEPTH_LOG2 words.
- overflow  out  1  sticky: a word was dropped because the buffer was full.

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE; wr_ptr, rd_ptr and count cleared.
  - io_rd_data=0, io_rd_ack=0, buf_full=0, overflow=0.
  - RAM contents are don't-care.
- Register map, decoded when io_sel & io_sync:
  - addr 0 CTRL, write-only. bit0=ARM, bit1=CLEAR, bit2=STOP. Reads return 0.
  - addr 1 STATUS, read-only: {overflow, buf_full, state[1:0], 21'b0, count[DEPTH_LOG2:0]}, count right-justified (bits [6:0] for the default).
  - addr 2 DATA_LO: returns head word [31:0]; no pop.
  - addr 3 DATA_HI: returns head word [63:32]; pops the head (rd_ptr++, count--) only when state is IDLE or DONE and count>0.
  - Writes to addr 1-3 are ignored.
- Read timing: io_rd_ack is asserted exactly one clk after a cycle with io_sync & io_sel & io_rd_en, for one cycle. io_rd_data is valid in that same cycle and holds its value until the next read.
- Read while empty: DATA_LO and DATA_HI return 32'h0; pointers unchanged.
- State machine:
  - IDLE -> ARMED on ARM.
  - ARMED -> CAPTURE on the first cycle with first_clk==1. The word on data_in in that cycle is itself eligible for capture.
  - CAPTURE -> DONE when count reaches 2^DEPTH_LOG2 or on STOP.
  - ARMED -> DONE on STOP.
  - DONE -> ARMED on ARM; the new capture appends to the unread contents.
  - Any state -> IDLE on CLEAR: pointers, count and overflow are zeroed.
- Capture rule: in CAPTURE, a word is written to RAM[wr_ptr], with wr_ptr++ and count++, when valid_in & en_proc and count < 2^DEPTH_LOG2. Zero-valued words are captured.
- Pointers wrap modulo 2^DEPTH_LOG2. count is DEPTH_LOG2+1 bits and never exceeds 2^DEPTH_LOG2.
- Overflow: a qualifying word arriving while count==2^DEPTH_LOG2 sets overflow. Overflow stays set until CLEAR or reset.
- Simultaneous CLEAR+ARM in one write: CLEAR applies first, final state is ARMED with an empty buffer.
- Simultaneous STOP+ARM in one write: STOP wins.
- Pops are suppressed in ARMED and CAPTURE: data is still returned, but the pointer is unchanged. This avoids a simultaneous pop and push.
- buf_full = (count == 2^DEPTH_LOG2), registered to track count.
- Reset mid-capture or mid-read: immediate return to the reset values listed above. A pending io_rd_ack is cancelled.

Decomposition:
- Shared package stub_readback_pkg:
  - register address constants REG_CTRL=0, REG_STATUS=1, REG_DATA_LO=2, REG_DATA_HI=3;
  - CTRL bit indices;
  - state encoding IDLE=0, ARMED=1, CAPTURE=2, DONE=3.
- One sub-module, readback_sdp_ram: simple dual-port RAM, 2^DEPTH_LOG2 x 64, one write port and one asynchronous-read port.
  - The asynchronous read is needed because head data must be presented with the 1-cycle read latency above.

Test Plan:
- Reset, read STATUS -> io_rd_data=0, io_rd_ack pulses 1 cycle after io_sync; buf_full=0, overflow=0.
- ARM, 3 cycles valid_in=1 with no first_clk, then first_clk with words 64'h1111_2222_3333_4444, ...+1, ...+2, then STOP -> STATUS count=3, state=DONE. DATA_LO then DATA_HI return 32'h3333_4444 and 32'h1111_2222, and count becomes 2.
- ARM + first_clk, then 70 consecutive valid words -> buf_full=1 and state=DONE after word 64, overflow=1. Draining returns exactly the first 64 words in order, and the final DATA_HI read leaves count=0.
- valid_in=1 with en_proc=0 during CAPTURE -> nothing captured, count unchanged.
- DATA_HI reads during CAPTURE -> head data returned, count unchanged. Empty-buffer DATA_LO in IDLE -> 32'h0.
- CLEAR+ARM in one write after an overflow -> state=ARMED, count=0, overflow=0. Drive reset=0 mid-capture -> all outputs return to their reset values on the next edge.
